psc_trigger_receiver: RTL
=========================

PSC_TRIGGER_RECEIVER -- requirements
Module: psc_trigger_receiver

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 5, clk cycles per serial bit (min 4).
REQ-002 SHALL have parameter MSG_LEN, default 16, bytes per message including trailing CRC byte (range 2..16).
REQ-003 SHALL have parameter TRIG_CODE, default 8'hA5, header byte value marking a trigger message.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port serial_in  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port byte_data  output  8  last received byte.
REQ-008 SHALL have port byte_valid  output  1  one-cycle strobe, byte_data valid.
REQ-009 SHALL have port trigger_pulse  output  1  one-cycle strobe, valid trigger message received.
REQ-010 SHALL have port frame_error  output  1  one-cycle strobe, bad start or stop bit.
REQ-011 SHALL have port crc_error  output  1  one-cycle strobe, message CRC mismatch.
REQ-012 SHALL have port msg_done  output  1  one-cycle strobe, message of MSG_LEN bytes completed (good or bad CRC).

Function
REQ-013 SHALL synchronise serial_in through two flops before any use.
REQ-014 Frame: 10 bits -- start 0, 8 data LSB first, stop 1.
REQ-015 FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE->START on synchronised 1->0 transition; START waits OVERSAMPLE/2 cycles (integer division), re-samples: 0 -> DATA, 1 -> IDLE, no error (glitch).
REQ-017 DATA samples one bit every OVERSAMPLE cycles, 8 samples, then -> STOP.
REQ-018 STOP samples after OVERSAMPLE cycles: 1 -> byte_valid high next cycle with byte_data updated; 0 -> frame_error strobe, message aborted; both -> IDLE.
REQ-019 byte_data SHALL hold its value until next valid byte.
REQ-020 Byte index 0..MSG_LEN-1 SHALL increment per valid byte and wrap to 0 after byte MSG_LEN-1.
REQ-021 On last byte: msg_done strobe in same cycle as its byte_valid; trigger_pulse in same cycle iff byte 0 == TRIG_CODE and CRC passes.
REQ-022 CRC-8: poly 0x07, init 0x00, MSB first, over bytes 0..MSG_LEN-2; passes iff result equals byte MSG_LEN-1; mismatch -> crc_error strobe with msg_done.
REQ-023 Idle timeout: line idle in IDLE for 20*OVERSAMPLE cycles with byte index nonzero SHALL reset index to 0 and CRC to init, no error strobe.
REQ-024 Frame error SHALL reset byte index and CRC to init; next byte starts a new message.
REQ-025 Total latency from stop-bit sample of last byte to trigger_pulse: 1 clk.

Reset
REQ-026 On reset: FSM IDLE, index 0, CRC 0x00, sync flops 1, byte_data 8'h00, all strobes 0.
REQ-027 Reset mid-frame SHALL discard partial byte and message with no strobes.

Configuration
REQ-028 Macro PSC_RX_CRC_CHECK_EN defined: CRC per REQ-022.
REQ-029 Macro undefined: no CRC logic, crc_error tied 0, last byte not checked, trigger_pulse depends on header only.

Structure
REQ-030 Shared package psc_trigger_pkg SHALL hold FSM state typedef, CRC polynomial constant, default TRIG_CODE, frame bit count.
REQ-031 CRC update SHALL be a sub-module psc_trigger_crc8 (byte in, crc in, crc out, combinational).

Verification
REQ-032 16-byte message A5,00..00 + correct CRC at OVERSAMPLE 5 -> 16 byte_valid, one msg_done, one trigger_pulse, crc_error 0.
REQ-033 Same with header 3C -> msg_done 1, trigger_pulse never asserted.
REQ-034 A5 message with CRC byte XOR 0x01 -> crc_error and msg_done same cycle, no trigger_pulse (macro defined); trigger_pulse with macro undefined.
REQ-035 Stop bit forced 0 on byte 3 -> frame_error once, next 16 good bytes with A5 header -> trigger_pulse.
REQ-036 2-cycle low glitch on idle line -> no strobes, FSM back to IDLE.
REQ-037 reset asserted during DATA of byte 7, then full good message -> outputs at reset values, then exactly one trigger_pulse.

Source files
------------

// File: rtl/psc_trigger_pkg.sv
// Shared types and constants for the PSC trigger receiver.
package psc_trigger_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam logic [7:0]  CRC8_POLY         = 8'h07;
    localparam logic [7:0]  DEFAULT_TRIG_CODE = 8'hA5;
    localparam int unsigned FRAME_BITS        = 10;
    localparam int unsigned DATA_BITS         = FRAME_BITS - 2;

endpackage

// File: rtl/psc_trigger_crc8.sv
// Combinational CRC-8 update of one byte, MSB first, polynomial CRC8_POLY.
module psc_trigger_crc8
    import psc_trigger_pkg::*;
(
    input  logic [7:0] byte_in,
    input  logic [7:0] crc_in,
    output logic [7:0] crc_out
);

    // Fold the byte into the CRC and shift it through eight polynomial steps.
    always_comb begin
        logic [7:0] c;
        c = crc_in ^ byte_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = (c << 1) ^ CRC8_POLY;
            end else begin
                c = c << 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/psc_trigger_receiver.sv
// PSC trigger receiver: oversampled UART-style byte receiver with message
// framing, header match and optional CRC-8 check of the trailing byte.
// Optional feature macro: PSC_RX_CRC_CHECK_EN (CRC check enabled when defined).
module psc_trigger_receiver
    import psc_trigger_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 5,
    parameter int unsigned MSG_LEN    = 16,
    parameter logic [7:0]  TRIG_CODE  = DEFAULT_TRIG_CODE
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       trigger_pulse,
    output logic       frame_error,
    output logic       crc_error,
    output logic       msg_done
);

    localparam int unsigned HALF       = OVERSAMPLE / 2;
    localparam int unsigned CNT_W      = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W      = $clog2(MSG_LEN);
    localparam int unsigned IDLE_LIMIT = 20 * OVERSAMPLE;
    localparam int unsigned IDLE_W     = $clog2(IDLE_LIMIT);

    logic             sync_1, sync_2, sync_prev;
    rx_state_t        state_q, state_next;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic [IDX_W-1:0] idx_q;
    logic             hdr_trig_q;
    logic [IDLE_W-1:0] idle_cnt_q;

    logic line_fall, start_sample, bit_sample, stop_sample;
    logic stop_good, stop_bad, last_byte, idle_timeout, crc_ok;

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1    <= 1'b1;
            sync_2    <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_1    <= serial_in;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign line_fall = sync_prev & ~sync_2;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:  if (line_fall) state_next = START;
            START: if (start_sample) state_next = sync_2 ? IDLE : DATA;
            DATA:  if (bit_sample && bit_cnt_q == 3'(DATA_BITS - 1)) state_next = STOP;
            STOP:  if (stop_sample) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM output decode: sampling points and message-level conditions.
    always_comb begin
        start_sample = (state_q == START) && (cnt_q == CNT_W'(HALF - 1));
        bit_sample   = (state_q == DATA)  && (cnt_q == CNT_W'(OVERSAMPLE - 1));
        stop_sample  = (state_q == STOP)  && (cnt_q == CNT_W'(OVERSAMPLE - 1));
        stop_good    = stop_sample & sync_2;
        stop_bad     = stop_sample & ~sync_2;
        last_byte    = (idx_q == IDX_W'(MSG_LEN - 1));
        idle_timeout = (state_q == IDLE) && sync_2 &&
                       (idle_cnt_q == IDLE_W'(IDLE_LIMIT - 1));
    end

    // Oversample counter: restarts on every state change and after each data bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if ((state_next != state_q) || bit_sample) begin
            cnt_q <= '0;
        end else if (state_q != IDLE) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Data shift register, LSB arrives first.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else if (start_sample) begin
            bit_cnt_q <= '0;
        end else if (bit_sample) begin
            shift_q   <= {sync_2, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
        end
    end

    // Idle-line counter, saturating at the timeout threshold.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else if ((state_q != IDLE) || !sync_2) begin
            idle_cnt_q <= '0;
        end else if (idle_cnt_q != IDLE_W'(IDLE_LIMIT - 1)) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end

    // Byte index within the message and header-match flag from byte 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q      <= '0;
            hdr_trig_q <= 1'b0;
        end else if (stop_bad || idle_timeout) begin
            idx_q <= '0;
        end else if (stop_good) begin
            idx_q <= last_byte ? '0 : idx_q + 1'b1;
            if (idx_q == '0) hdr_trig_q <= (shift_q == TRIG_CODE);
        end
    end

`ifdef PSC_RX_CRC_CHECK_EN
    logic [7:0] crc_q, crc_next;

    psc_trigger_crc8 u_crc (
        .byte_in (shift_q),
        .crc_in  (crc_q),
        .crc_out (crc_next)
    );

    // Running CRC over payload bytes; cleared at message end, abort or timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= '0;
        end else if (stop_bad || idle_timeout) begin
            crc_q <= '0;
        end else if (stop_good) begin
            crc_q <= last_byte ? '0 : crc_next;
        end
    end

    // The last byte of a message is the expected CRC.
    always_comb crc_ok = (crc_q == shift_q);

    // CRC mismatch strobe, aligned with msg_done.
    always_ff @(posedge clk) begin
        if (reset) crc_error <= 1'b0;
        else       crc_error <= stop_good & last_byte & ~crc_ok;
    end
`else
    // Without CRC checking every message is accepted on its header alone.
    always_comb begin
        crc_ok    = 1'b1;
        crc_error = 1'b0;
    end
`endif

    // Registered strobes and byte output, one cycle after the stop-bit sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_data     <= '0;
            byte_valid    <= 1'b0;
            frame_error   <= 1'b0;
            msg_done      <= 1'b0;
            trigger_pulse <= 1'b0;
        end else begin
            byte_valid    <= stop_good;
            frame_error   <= stop_bad;
            msg_done      <= stop_good & last_byte;
            trigger_pulse <= stop_good & last_byte & hdr_trig_q & crc_ok;
            if (stop_good) byte_data <= shift_q;
        end
    end

endmodule
